// File: rtl/sdram_cmd_pkg.sv
// Shared SDRAM command-bus definitions: command encodings as seen on
// {cs_n,ras_n,cas_n,we_n}, monitor error-flag bit positions and small decode helpers.
package sdram_cmd_pkg;

  // Encodings with cs_n=0; anything with cs_n=1 is a deselect (INH).
  typedef enum logic [3:0] {
    CMD_MRS  = 4'b0000,
    CMD_AREF = 4'b0001,
    CMD_PRE  = 4'b0010,
    CMD_ACT  = 4'b0011,
    CMD_WR   = 4'b0100,
    CMD_RD   = 4'b0101,
    CMD_BST  = 4'b0110,
    CMD_NOP  = 4'b0111
  } sdram_cmd_e;

  // Sticky error flag bit positions.
  localparam int ERR_TRP      = 0;
  localparam int ERR_TRFC     = 1;
  localparam int ERR_TMRD     = 2;
  localparam int ERR_TRCD     = 3;
  localparam int ERR_REF_LATE = 4;
  localparam int ERR_ILLEGAL  = 5;
  localparam int ERR_W        = 6;

  // Address bit selecting all-bank precharge.
  localparam int A10_BIT = 10;

  // Width of the command-spacing timers (enough for T_RFC-1).
  localparam int TMR_W = 4;

  // Map the raw bus value to a command; deselect or a disabled monitor reads as NOP.
  function automatic sdram_cmd_e cmd_decode(input logic [3:0] raw, input logic en);
    if (!en || raw[3]) begin
      return CMD_NOP;
    end else begin
      return sdram_cmd_e'(raw);
    end
  endfunction

  // Commands other than NOP/BST (and deselect) are subject to spacing rules.
  function automatic logic cmd_is_active(input sdram_cmd_e cmd);
    case (cmd)
      CMD_NOP, CMD_BST: return 1'b0;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sdram_mon_timer.sv
// Down-counting spacing timer: loaded by a strobe, runs down to zero,
// busy while nonzero. A load always wins over the running count.
module sdram_mon_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         busy_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on strobe, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command-bus monitor: tracks bank state, mode register and
// refresh cadence, and flags spacing / protocol violations (sticky + pulse).
module sdram_cmd_monitor
  import sdram_cmd_pkg::*;
#(
  parameter int T_RP       = 2,
  parameter int T_RFC      = 7,
  parameter int T_MRD      = 2,
  parameter int T_RCD      = 2,
  parameter int REF_PERIOD = 750,
  parameter int CNT_W      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mon_en,
  input  logic        err_clr,
  input  logic [3:0]  sdram_cmd,
  input  logic [1:0]  sdram_bank,
  input  logic [12:0] sdram_addr,
  output logic [3:0]  bank_open,
  output logic [12:0] mode_reg,
  output logic        mode_valid,
  output logic [15:0] aref_cnt,
  output logic        err_pulse,
  output logic [5:0]  err_flags
);

  localparam logic [CNT_W-1:0] REF_LIMIT    = CNT_W'(REF_PERIOD);
  localparam logic [CNT_W-1:0] REF_LIMIT_M1 = CNT_W'(REF_PERIOD - 1);

  sdram_cmd_e       cmd_s;
  logic             active_s;
  logic             trp_busy_s;
  logic             trfc_busy_s;
  logic             tmrd_busy_s;
  logic [3:0]       trcd_busy_s;
  logic [3:0]       trcd_load_s;
  logic [ERR_W-1:0] viol_s;

  logic [3:0]       bank_open_q,  bank_open_d;
  logic [12:0]      mode_reg_q,   mode_reg_d;
  logic             mode_valid_q, mode_valid_d;
  logic [15:0]      aref_cnt_q,   aref_cnt_d;
  logic             err_pulse_q,  err_pulse_d;
  logic [ERR_W-1:0] err_flags_q,  err_flags_d;
  logic [CNT_W-1:0] ref_cnt_q,    ref_cnt_d;
  logic             ref_armed_q,  ref_armed_d;

  assign cmd_s    = cmd_decode(sdram_cmd, mon_en);
  assign active_s = cmd_is_active(cmd_s);

  sdram_mon_timer #(.W(TMR_W)) u_trp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cmd_s == CMD_PRE),
    .load_val_i (TMR_W'(T_RP - 1)),
    .busy_o     (trp_busy_s)
  );

  sdram_mon_timer #(.W(TMR_W)) u_trfc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cmd_s == CMD_AREF),
    .load_val_i (TMR_W'(T_RFC - 1)),
    .busy_o     (trfc_busy_s)
  );

  sdram_mon_timer #(.W(TMR_W)) u_tmrd (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cmd_s == CMD_MRS),
    .load_val_i (TMR_W'(T_MRD - 1)),
    .busy_o     (tmrd_busy_s)
  );

  for (genvar i = 0; i < 4; i++) begin : g_trcd
    assign trcd_load_s[i] = (cmd_s == CMD_ACT) && (sdram_bank == 2'(i));
    sdram_mon_timer #(.W(TMR_W)) u_trcd (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (trcd_load_s[i]),
      .load_val_i (TMR_W'(T_RCD - 1)),
      .busy_o     (trcd_busy_s[i])
    );
  end

  // Classify the current command into violation bits.
  always_comb begin
    viol_s = '0;
    if (active_s) begin
      viol_s[ERR_TRP]  = trp_busy_s;
      viol_s[ERR_TRFC] = trfc_busy_s;
      viol_s[ERR_TMRD] = tmrd_busy_s;
    end else begin
      viol_s[ERR_TRP]  = 1'b0;
      viol_s[ERR_TRFC] = 1'b0;
      viol_s[ERR_TMRD] = 1'b0;
    end
    case (cmd_s)
      CMD_ACT: begin
        viol_s[ERR_ILLEGAL] = bank_open_q[sdram_bank];
      end
      CMD_RD, CMD_WR: begin
        viol_s[ERR_TRCD]    = trcd_busy_s[sdram_bank];
        viol_s[ERR_ILLEGAL] = ~bank_open_q[sdram_bank];
      end
      CMD_AREF, CMD_MRS: begin
        viol_s[ERR_ILLEGAL] = |bank_open_q;
      end
      default: begin
        viol_s[ERR_ILLEGAL] = 1'b0;
      end
    endcase
    // Fires once, on the cycle the interval counter would reach the limit.
    if (mon_en && ref_armed_q && (cmd_s != CMD_AREF) && (ref_cnt_q == REF_LIMIT_M1)) begin
      viol_s[ERR_REF_LATE] = 1'b1;
    end else begin
      viol_s[ERR_REF_LATE] = 1'b0;
    end
  end

  // Next-state for bank/mode/refresh tracking and error reporting.
  always_comb begin
    bank_open_d  = bank_open_q;
    mode_reg_d   = mode_reg_q;
    mode_valid_d = mode_valid_q;
    aref_cnt_d   = aref_cnt_q;
    ref_cnt_d    = ref_cnt_q;
    ref_armed_d  = ref_armed_q;

    case (cmd_s)
      CMD_ACT: begin
        bank_open_d[sdram_bank] = 1'b1;
      end
      CMD_PRE: begin
        if (sdram_addr[A10_BIT]) begin
          bank_open_d = 4'b0000;
        end else begin
          bank_open_d[sdram_bank] = 1'b0;
        end
      end
      CMD_MRS: begin
        mode_reg_d   = sdram_addr;
        mode_valid_d = 1'b1;
      end
      CMD_AREF: begin
        aref_cnt_d = aref_cnt_q + 16'd1;
      end
      default: begin
        bank_open_d = bank_open_q;
      end
    endcase

    // Refresh interval counter: disarmed while monitoring is off,
    // restarted by each AREF, saturating at the limit.
    if (!mon_en) begin
      ref_cnt_d   = '0;
      ref_armed_d = 1'b0;
    end else if (cmd_s == CMD_AREF) begin
      ref_cnt_d   = '0;
      ref_armed_d = 1'b1;
    end else if (ref_armed_q && (ref_cnt_q != REF_LIMIT)) begin
      ref_cnt_d = ref_cnt_q + CNT_W'(1);
    end else begin
      ref_cnt_d = ref_cnt_q;
    end

    // A violation in the same cycle as a clear survives the clear.
    if (err_clr) begin
      err_flags_d = viol_s;
    end else begin
      err_flags_d = err_flags_q | viol_s;
    end
    err_pulse_d = |viol_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open_q  <= 4'b0000;
      mode_reg_q   <= 13'd0;
      mode_valid_q <= 1'b0;
      aref_cnt_q   <= 16'd0;
      err_pulse_q  <= 1'b0;
      err_flags_q  <= '0;
      ref_cnt_q    <= '0;
      ref_armed_q  <= 1'b0;
    end else begin
      bank_open_q  <= bank_open_d;
      mode_reg_q   <= mode_reg_d;
      mode_valid_q <= mode_valid_d;
      aref_cnt_q   <= aref_cnt_d;
      err_pulse_q  <= err_pulse_d;
      err_flags_q  <= err_flags_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_armed_q  <= ref_armed_d;
    end
  end

  assign bank_open  = bank_open_q;
  assign mode_reg   = mode_reg_q;
  assign mode_valid = mode_valid_q;
  assign aref_cnt   = aref_cnt_q;
  assign err_pulse  = err_pulse_q;
  assign err_flags  = err_flags_q;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Bench for sdram_cmd_monitor: directed sequences plus random traffic,
// checked every cycle against a timestamp-based reference model.
module tb_sdram_cmd_monitor;
  import sdram_cmd_pkg::*;

  localparam int T_RP       = 2;
  localparam int T_RFC      = 7;
  localparam int T_MRD      = 2;
  localparam int T_RCD      = 2;
  localparam int REF_PERIOD = 750;
  localparam int CNT_W      = 10;
  localparam int FAR_PAST   = -100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mon_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [3:0]  sdram_cmd = 4'b0111;
  logic [1:0]  sdram_bank = 2'd0;
  logic [12:0] sdram_addr = 13'd0;
  logic [3:0]  bank_open;
  logic [12:0] mode_reg;
  logic        mode_valid;
  logic [15:0] aref_cnt;
  logic        err_pulse;
  logic [5:0]  err_flags;

  always #5 clk = ~clk;

  sdram_cmd_monitor #(
    .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .T_RCD(T_RCD),
    .REF_PERIOD(REF_PERIOD), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mon_en     (mon_en),
    .err_clr    (err_clr),
    .sdram_cmd  (sdram_cmd),
    .sdram_bank (sdram_bank),
    .sdram_addr (sdram_addr),
    .bank_open  (bank_open),
    .mode_reg   (mode_reg),
    .mode_valid (mode_valid),
    .aref_cnt   (aref_cnt),
    .err_pulse  (err_pulse),
    .err_flags  (err_flags)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remembers when each command was last issued and
  // judges spacing by elapsed cycles.
  int          cyc;
  int          last_pre, last_aref, last_mrs;
  int          last_act [4];
  bit          m_armed;
  logic [3:0]  m_open;
  logic [12:0] m_mode;
  logic        m_mvalid;
  logic [15:0] m_aref;
  logic        m_pulse;
  logic [5:0]  m_flags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_pre  = FAR_PAST;
    last_aref = FAR_PAST;
    last_mrs  = FAR_PAST;
    for (int i = 0; i < 4; i++) last_act[i] = FAR_PAST;
    m_armed  = 1'b0;
    m_open   = 4'b0000;
    m_mode   = 13'd0;
    m_mvalid = 1'b0;
    m_aref   = 16'd0;
    m_pulse  = 1'b0;
    m_flags  = 6'd0;
  endtask

  task automatic model_step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                            input logic en, input logic clr);
    logic [3:0] cmd;
    logic [5:0] v;
    bit         active;
    cmd    = (!en || c[3]) ? 4'b0111 : c;
    active = !((cmd == CMD_NOP) || (cmd == CMD_BST));
    v      = 6'd0;
    if (active) begin
      if (cyc - last_pre  < T_RP)  v[0] = 1'b1;
      if (cyc - last_aref < T_RFC) v[1] = 1'b1;
      if (cyc - last_mrs  < T_MRD) v[2] = 1'b1;
    end
    if ((cmd == CMD_RD) || (cmd == CMD_WR)) begin
      if (cyc - last_act[b] < T_RCD) v[3] = 1'b1;
      if (!m_open[b]) v[5] = 1'b1;
    end
    if ((cmd == CMD_ACT) && m_open[b]) v[5] = 1'b1;
    if (((cmd == CMD_AREF) || (cmd == CMD_MRS)) && (m_open != 4'b0000)) v[5] = 1'b1;
    if (en && m_armed && (cmd != CMD_AREF) && (cyc - last_aref == REF_PERIOD)) v[4] = 1'b1;

    m_flags = (clr ? 6'd0 : m_flags) | v;
    m_pulse = (v != 6'd0);

    if (cmd == CMD_ACT) begin
      last_act[b] = cyc;
      m_open[b]   = 1'b1;
    end
    if (cmd == CMD_PRE) begin
      last_pre = cyc;
      if (a[10]) m_open = 4'b0000;
      else       m_open[b] = 1'b0;
    end
    if (cmd == CMD_AREF) begin
      last_aref = cyc;
      m_aref    = m_aref + 16'd1;
      m_armed   = 1'b1;
    end
    if (cmd == CMD_MRS) begin
      last_mrs = cyc;
      m_mode   = a;
      m_mvalid = 1'b1;
    end
    if (!en) m_armed = 1'b0;
    cyc++;
  endtask

  task automatic check_all(input string where);
    check({where, ".bank_open"},  {28'd0, bank_open},  {28'd0, m_open});
    check({where, ".mode_reg"},   {19'd0, mode_reg},   {19'd0, m_mode});
    check({where, ".mode_valid"}, {31'd0, mode_valid}, {31'd0, m_mvalid});
    check({where, ".aref_cnt"},   {16'd0, aref_cnt},   {16'd0, m_aref});
    check({where, ".err_pulse"},  {31'd0, err_pulse},  {31'd0, m_pulse});
    check({where, ".err_flags"},  {26'd0, err_flags},  {26'd0, m_flags});
  endtask

  // One bus cycle: drive at the falling edge, model the rising edge, sample just after.
  task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                      input logic en, input logic clr);
    @(negedge clk);
    sdram_cmd  = c;
    sdram_bank = b;
    sdram_addr = a;
    mon_en     = en;
    err_clr    = clr;
    @(posedge clk);
    model_step(c, b, a, en, clr);
    #1;
    check_all("cyc");
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    step(c, b, a, 1'b1, 1'b0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(CMD_NOP, 2'd0, 13'd0, 1'b1, 1'b0);
  endtask

  task automatic clear_errs();
    step(CMD_NOP, 2'd0, 13'd0, 1'b1, 1'b1);
  endtask

  // Asynchronous reset asserted between clock edges and released at a falling edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    sdram_cmd = 4'b0111;
    rst_n     = 1'b1;
  endtask

  logic [15:0] saved_aref;

  initial begin
    cyc = 0;
    model_reset();
    async_reset();

    // Legal initialisation sequence.
    cmd(CMD_PRE, 2'd0, 13'h0400);
    nops(2);
    cmd(CMD_AREF, 2'd0, 13'd0);
    nops(7);
    cmd(CMD_AREF, 2'd0, 13'd0);
    nops(7);
    cmd(CMD_MRS, 2'd0, 13'h0032);
    nops(2);
    check("init.flags", {26'd0, err_flags}, 32'd0);
    check("init.aref",  {16'd0, aref_cnt},  32'd2);
    check("init.mode",  {19'd0, mode_reg},  32'h32);
    check("init.mvalid", {31'd0, mode_valid}, 32'd1);

    // tRP then tRFC violations.
    cmd(CMD_PRE, 2'd0, 13'h0400);
    cmd(CMD_AREF, 2'd0, 13'd0);
    check("trp.pulse", {31'd0, err_pulse}, 32'd1);
    check("trp.flag",  {31'd0, err_flags[0]}, 32'd1);
    nops(1);
    check("trp.pulse_end", {31'd0, err_pulse}, 32'd0);
    nops(7);
    cmd(CMD_AREF, 2'd0, 13'd0);
    nops(2);
    cmd(CMD_ACT, 2'd0, 13'd0);
    check("trfc.flag", {31'd0, err_flags[1]}, 32'd1);
    nops(8);
    clear_errs();
    check("clr.flags", {26'd0, err_flags}, 32'd0);

    // tRCD per bank.
    cmd(CMD_ACT, 2'd1, 13'd0);
    cmd(CMD_WR,  2'd1, 13'd0);
    check("trcd.flag", {31'd0, err_flags[3]}, 32'd1);
    nops(3);
    clear_errs();
    cmd(CMD_ACT, 2'd2, 13'd0);
    cmd(CMD_WR,  2'd3, 13'd0);
    check("closed.ill",  {31'd0, err_flags[5]}, 32'd1);
    check("closed.trcd", {31'd0, err_flags[3]}, 32'd0);
    nops(2);
    cmd(CMD_PRE, 2'd0, 13'h0400);
    nops(2);
    clear_errs();

    // Bank tracking.
    cmd(CMD_ACT, 2'd0, 13'd0);
    cmd(CMD_ACT, 2'd2, 13'd0);
    check("bank.two_open", {28'd0, bank_open}, 32'h5);
    cmd(CMD_PRE, 2'd0, 13'd0);
    check("bank.pre_one", {28'd0, bank_open}, 32'h4);
    nops(2);
    cmd(CMD_AREF, 2'd0, 13'd0);
    check("bank.aref_ill", {31'd0, err_flags[5]}, 32'd1);
    nops(7);
    cmd(CMD_PRE, 2'd1, 13'h0400);
    check("bank.pre_all", {28'd0, bank_open}, 32'h0);
    nops(2);
    clear_errs();

    // Late refresh.
    cmd(CMD_AREF, 2'd0, 13'd0);
    nops(REF_PERIOD - 1);
    check("ref.not_yet", {31'd0, err_flags[4]}, 32'd0);
    nops(1);
    check("ref.flag",  {31'd0, err_flags[4]}, 32'd1);
    check("ref.pulse", {31'd0, err_pulse}, 32'd1);
    nops(5);
    cmd(CMD_AREF, 2'd0, 13'd0);
    clear_errs();
    check("ref.cleared", {26'd0, err_flags}, 32'd0);
    nops(8);

    // Reset during a tRFC countdown with banks open.
    cmd(CMD_ACT, 2'd0, 13'd0);
    cmd(CMD_ACT, 2'd1, 13'd0);
    nops(2);
    cmd(CMD_AREF, 2'd0, 13'd0);
    nops(1);
    async_reset();
    check("mid_rst.open",  {28'd0, bank_open}, 32'd0);
    check("mid_rst.flags", {26'd0, err_flags}, 32'd0);
    check("mid_rst.aref",  {16'd0, aref_cnt},  32'd0);
    cmd(CMD_ACT, 2'd3, 13'd0);
    check("post_rst.flags", {26'd0, err_flags}, 32'd0);
    nops(2);
    cmd(CMD_PRE, 2'd0, 13'h0400);
    nops(2);

    // Monitor disabled: back-to-back PRE/AREF are ignored.
    saved_aref = m_aref;
    step(CMD_PRE,  2'd0, 13'h0400, 1'b0, 1'b0);
    step(CMD_AREF, 2'd0, 13'd0,    1'b0, 1'b0);
    check("dis.flags", {26'd0, err_flags}, 32'd0);
    check("dis.aref",  {16'd0, aref_cnt},  {16'd0, saved_aref});
    nops(8);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [3:0]  c;
      logic [1:0]  b;
      logic [12:0] a;
      logic        en, clr;
      r = $urandom_range(0, 99);
      if      (r < 40) c = CMD_NOP;
      else if (r < 45) c = {1'b1, 3'($urandom)};
      else if (r < 50) c = CMD_BST;
      else if (r < 62) c = CMD_ACT;
      else if (r < 70) c = CMD_RD;
      else if (r < 78) c = CMD_WR;
      else if (r < 88) c = CMD_PRE;
      else if (r < 95) c = CMD_AREF;
      else             c = CMD_MRS;
      b   = 2'($urandom);
      a   = 13'($urandom);
      en  = ($urandom_range(0, 99) < 95);
      clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 499) == 0) async_reset();
      step(c, b, a, en, clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_cmd_monitor.md
Name: sdram_cmd_monitor

Overview:
- Passive responder-side observer of the SDRAM command bus: samples {cs_n,ras_n,cas_n,we_n}, bank and address exactly as the SDRAM device sees them.
- Tracks bank open/closed state, mode-register writes and auto-refresh cadence.
- Flags timing and protocol violations: tRP, tRFC, tMRD, tRCD, refresh interval, illegal state.
- Sits beside the device model in ctrl benches and can be synthesized as an on-chip bus checker behind the init/aref/rw arbiter.

Parameters:
- T_RP, 2, min cycles PRECHARGE -> next command
- T_RFC, 7, min cycles AUTO REFRESH -> next command
- T_MRD, 2, min cycles MODE REGISTER SET -> next command
- T_RCD, 2, min cycles ACTIVE -> READ/WRITE same bank
- REF_PERIOD, 750, max cycles between AUTO REFRESH commands (7.5 us @ 100 MHz)
- CNT_W, 10, width of refresh-interval counter (must hold REF_PERIOD)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- mon_en  in  1  monitor enable; 0 = all commands treated as NOP
- err_clr  in  1  clears sticky err_flags
- sdram_cmd  in  4  {cs_n,ras_n,cas_n,we_n}
- sdram_bank  in  2  bank address
- sdram_addr  in  13  address (A10 = all-bank on PRECHARGE)
- bank_open  out  4  1 = bank row active
- mode_reg  out  13  last MRS address value
- mode_valid  out  1  at least one MRS seen
- aref_cnt  out  16  AUTO REFRESH count, wraps 0xFFFF->0
- err_pulse  out  1  one-cycle pulse on any new violation
- err_flags  out  6  sticky: [0] tRP, [1] tRFC, [2] tMRD, [3] tRCD, [4] refresh late, [5] illegal state

Behaviour:
- Decode: INH cs_n=1; NOP 0111; ACT 0011; RD 0101; WR 0100; BST 0110; PRE 0010; AREF 0001; MRS 0000. INH, NOP, BST are "idle"; all others are "active".
- All outputs registered; effects of the command sampled at edge N are visible after edge N (1-cycle latency).
- Reset (async, any time including mid-sequence): all outputs 0, all timers 0, refresh counter disarmed.
- Timers (tRP, tRFC, tMRD, tRCD x4):
  - Loaded with T_x-1 at the issuing command; decrement by 1 while nonzero.
  - An active command sampled while a relevant timer is nonzero is a violation.
  - Example T_RP=2: PRE@0, any active cmd@1 -> err; @2 -> OK.
  - tRP/tRFC/tMRD are global. tRCD is per bank and checked only by RD/WR to that bank.
  - A new issuing command reloads its timer even if the timer is running.
- Bank state:
  - ACT sets bank_open[bank]; ACT to an already open bank -> flag[5].
  - PRE with A10=1 clears all banks; A10=0 clears the addressed bank. PRE to a closed bank is legal.
  - RD/WR to a closed bank -> flag[5].
  - AREF or MRS with any bank open -> flag[5]; the command is still counted and applied.
- MRS: mode_reg <= sdram_addr, mode_valid <= 1.
- Refresh interval:
  - Counter is armed by the first AREF; counts cycles since the last AREF and clears to 0 on each AREF.
  - On reaching REF_PERIOD: flag[4] set, err_pulse once, counter saturates until the next AREF.
- Multiple violations on one command: set all applicable flags, single err_pulse.
- err_clr concurrent with a new violation: the new flag bit is set; other bits clear.
- mon_en=0:
  - Decode is forced to NOP.
  - Timers keep running down.
  - Refresh counter held at 0 and disarmed.
  - bank_open, mode_reg and aref_cnt hold.

Decomposition:
- Shared package sdram_cmd_pkg: command encodings (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_BST, CMD_PRE, CMD_AREF, CMD_MRS), err_flags bit indices. The same constants are reused by the init/aref/rw controllers.
- One sub-module, sdram_mon_timer: load value, load strobe, down-count, busy output. Instantiated 7 times (tRP, tRFC, tMRD, tRCD[0..3]).

Test Plan:
- Legal init: reset, PRE A10=1, NOP, NOP, AREF, 7 NOP, AREF, 7 NOP, MRS addr=0x032, NOP, NOP -> err_flags=0, aref_cnt=2, mode_reg=0x032, mode_valid=1.
- tRP/tRFC violations: PRE then AREF on next cycle -> err_pulse 1 cycle, flags[0]=1. AREF then ACT 3 cycles later -> flags[1]=1.
- tRCD per bank: ACT bank1, next cycle WR bank1 -> flags[3]. ACT bank2, next cycle WR bank3 (closed) -> flags[5] only, flags[3] clear.
- Bank tracking: ACT banks 0,2 -> bank_open=4'b0101. PRE bank0 A10=0 -> 4'b0100. AREF -> flags[5]. PRE A10=1 -> 4'b0000.
- Refresh late: AREF then 750 NOP cycles -> flags[4] set at cycle 750, single err_pulse. Next AREF clears the counter. err_clr -> flags=0.
- Reset mid-operation and mon_en: assert rst_n=0 during tRFC countdown with banks open -> all outputs 0. mon_en=0 with PRE followed by AREF -> no error, aref_cnt unchanged.
